if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: instruction buffer entries; only 2 is supported.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 pc_i  in  32  fetch address from the PC register.
REQ-005 pc_ce_i  in  1  pc_i valid (PC register enabled).
REQ-006 flush_i  in  1  redirect; discard all fetched/in-flight work.
REQ-007 fetch_stall_o  out  1  PC register holds pc_i next cycle.
REQ-008 inst_req_o  out  1  instruction bus request.
REQ-009 inst_addr_o  out  32  instruction bus address.
REQ-010 inst_addr_ok_i  in  1  request accepted by bus.
REQ-011 inst_data_ok_i  in  1  read data returned.
REQ-012 inst_rdata_i  in  32  returned instruction.
REQ-013 id_valid_o  out  1  buffer head valid toward ID.
REQ-014 id_ready_i  in  1  ID consumes head.
REQ-015 id_pc_o  out  32  PC of head entry.
REQ-016 id_inst_o  out  32  instruction of head entry.
REQ-017 id_adel_o  out  1  head entry has a misaligned-fetch exception.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DISCARD, with at most one outstanding bus transaction.
REQ-019 Capture SHALL occur when state==IDLE, pc_ce_i=1, flush_i=0 and count<2; fetch_stall_o = pc_ce_i & ~capture (combinational).
REQ-020 On capture with pc_i[1:0]==0, the block SHALL register pc_i into the address register and move to REQ.
REQ-021 On capture with pc_i[1:0]!=0, the block SHALL issue no bus request, SHALL push {pc_i, 32'h0, adel=1} and SHALL stay in IDLE.
REQ-022 In REQ, inst_req_o SHALL be 1 and inst_addr_o SHALL equal the address register, held stable until inst_addr_ok_i; in all other states inst_req_o SHALL be 0.
REQ-023 REQ with inst_addr_ok_i SHALL go to WAIT, or to DISCARD if flush_i is 1 in that cycle or any earlier REQ cycle of the transaction.
REQ-024 A flush in REQ SHALL NOT retract the request: inst_req_o remains 1 until addr_ok.
REQ-025 WAIT with inst_data_ok_i and flush_i=0 SHALL push {addr, inst_rdata_i, adel=0} and go to IDLE.
REQ-026 WAIT with flush_i=1 SHALL go to DISCARD, or to IDLE without a push if inst_data_ok_i is 1 in the same cycle.
REQ-027 DISCARD SHALL drop the next inst_data_ok_i response, then go to IDLE.
REQ-028 The FIFO SHALL pop when id_valid_o & id_ready_i; id_* SHALL show the head entry, and id_valid_o = (count!=0).
REQ-029 Capture requires count<2 and an outstanding fetch exists only after capture, so push SHALL never overflow; simultaneous push and pop SHALL leave count unchanged.
REQ-030 flush_i=1 SHALL empty the FIFO at the next edge, overriding any same-cycle push or pop.
REQ-031 The best-case latency SHALL be: capture at cycle t, request at t+1, data_ok at t+2, id_valid_o=1 at t+3.

Reset
REQ-032 While rst_n_i=0, the block SHALL force state=IDLE, count=0, address register=0, a cleared discard flag, inst_req_o=0, inst_addr_o=0 and id_valid_o=0; id_pc_o, id_inst_o and id_adel_o SHALL read 0.
REQ-033 Any bus response arriving after reset deassertion with no outstanding request SHALL be ignored.

Structure
REQ-034 Package if_pkg SHALL hold the fetch_state_e enum (IDLE/REQ/WAIT/DISCARD), the fetch_entry_t struct {pc[31:0], inst[31:0], adel} and the FIFO_DEPTH constant.
REQ-035 The buffer SHALL be a sub-module if_fifo (push/pop/flush, count, head out), with reset asynchronous and active-low.

Verification
REQ-036 pc_i=0xBFC00000 with pc_ce_i=1, addr_ok at t+1, data_ok with 0x24080001 at t+2, id_ready=1 -> id_valid_o=1 at t+3 with id_pc_o=0xBFC00000 and id_inst_o=0x24080001.
REQ-037 id_ready_i=0 for three fetches 0x0, 0x4, 0x8 -> two entries buffered, fetch_stall_o=1 holding 0x8, no request issued until one pop.
REQ-038 flush_i pulsed in WAIT before data_ok for 0x100 -> response discarded, FIFO empty, the next capture 0x200 delivered alone.
REQ-039 flush_i in REQ with addr_ok delayed 3 cycles -> inst_req_o stays 1 with address stable, the response is dropped in DISCARD, and no push occurs.
REQ-040 pc_i=0x00000006 -> no inst_req_o, id_adel_o=1, id_pc_o=0x6 and id_inst_o=0.
REQ-041 rst_n_i asserted in WAIT with data_ok arriving 1 cycle after release -> state IDLE, id_valid_o stays 0, response ignored.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small instruction buffer between fetch and decode; flush empties it
// and takes priority over any same-cycle push or pop.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  fetch_entry_t  entry_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    // An empty buffer presents zeros so stale entries never leak to decode.
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: one outstanding instruction-bus read at a time,
// results (or misaligned-fetch exceptions) queued for decode.
module if_fetch_ctrl #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_i,
    input  logic        pc_ce_i,
    input  logic        flush_i,
    output logic        fetch_stall_o,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_adel_o
);

    import if_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          discard_q, discard_d;
    logic          capture, push, pop;
    fetch_entry_t  push_entry, head;
    logic [CW-1:0] fifo_count;

    assign capture       = (state_q == IDLE) && pc_ce_i && !flush_i
                           && (fifo_count < CW'(FIFO_DEPTH));
    assign fetch_stall_o = pc_ce_i & ~capture;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        push       = 1'b0;
        push_entry = '0;
        inst_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    if (pc_i[1:0] == 2'b00) begin
                        addr_d  = pc_i;
                        state_d = REQ;
                    end else begin
                        push       = 1'b1;
                        push_entry = '{pc: pc_i, inst: 32'h0, adel: 1'b1};
                    end
                end
            end
            REQ: begin
                // The request cannot be withdrawn; a flush is remembered
                // until the bus accepts, then the reply is dropped.
                inst_req_o = 1'b1;
                if (inst_addr_ok_i) begin
                    state_d   = (discard_q || flush_i) ? DISCARD : WAIT;
                    discard_d = 1'b0;
                end else begin
                    discard_d = discard_q | flush_i;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = inst_data_ok_i ? IDLE : DISCARD;
                end else if (inst_data_ok_i) begin
                    push       = 1'b1;
                    push_entry = '{pc: addr_q, inst: inst_rdata_i, adel: 1'b0};
                    state_d    = IDLE;
                end
            end
            DISCARD: begin
                if (inst_data_ok_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_addr_o = addr_q;
    assign id_valid_o  = (fifo_count != '0);
    assign pop         = id_valid_o & id_ready_i;

    if_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (flush_i),
        .count_o (fifo_count),
        .head_o  (head)
    );

    assign id_pc_o   = head.pc;
    assign id_inst_o = head.inst;
    assign id_adel_o = head.adel;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with hand-computed expectations.
module tb_if_fetch_ctrl;

    logic        clk_i, rst_n_i;
    logic [31:0] pc_i;
    logic        pc_ce_i, flush_i;
    logic        fetch_stall_o, inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i, inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        id_valid_o, id_ready_i;
    logic [31:0] id_pc_o, id_inst_o;
    logic        id_adel_o;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_ctrl #(.FIFO_DEPTH(2)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .pc_i           (pc_i),
        .pc_ce_i        (pc_ce_i),
        .flush_i        (flush_i),
        .fetch_stall_o  (fetch_stall_o),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i),
        .id_valid_o     (id_valid_o),
        .id_ready_i     (id_ready_i),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o),
        .id_adel_o      (id_adel_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Best-case fetch: capture, addr_ok next cycle, data_ok the cycle after.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
        pc_i = pc; pc_ce_i = 1'b1;
        #1 chk("cap_stall", fetch_stall_o, 0);
        tick();
        pc_ce_i = 1'b0; inst_addr_ok_i = 1'b1;
        #1 chk("req", inst_req_o, 1);
        chk("req_addr", inst_addr_o, pc);
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = data;
        tick();
        inst_data_ok_i = 1'b0;
    endtask

    initial begin
        rst_n_i = 1'b0; pc_i = '0; pc_ce_i = 1'b0; flush_i = 1'b0;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
        id_ready_i = 1'b0;
        tick(); tick();
        chk("rst_req", inst_req_o, 0);
        chk("rst_addr", inst_addr_o, 0);
        chk("rst_valid", id_valid_o, 0);
        chk("rst_pc", id_pc_o, 0);
        chk("rst_inst", id_inst_o, 0);
        chk("rst_adel", id_adel_o, 0);
        chk("rst_stall", fetch_stall_o, 0);
        rst_n_i = 1'b1;
        tick();

        // Best-case latency from reset vector
        id_ready_i = 1'b1;
        pc_i = 32'hBFC0_0000; pc_ce_i = 1'b1;
        #1 chk("t0_stall", fetch_stall_o, 0);
        chk("t0_req", inst_req_o, 0);
        tick();
        pc_ce_i = 1'b0; inst_addr_ok_i = 1'b1;
        #1 chk("t1_req", inst_req_o, 1);
        chk("t1_addr", inst_addr_o, 32'hBFC0_0000);
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h2408_0001;
        #1 chk("t2_req", inst_req_o, 0);
        chk("t2_valid", id_valid_o, 0);
        tick();
        inst_data_ok_i = 1'b0;
        #1 chk("t3_valid", id_valid_o, 1);
        chk("t3_pc", id_pc_o, 32'hBFC0_0000);
        chk("t3_inst", id_inst_o, 32'h2408_0001);
        chk("t3_adel", id_adel_o, 0);
        tick();
        chk("t4_empty", id_valid_o, 0);

        // Backpressure: two buffered, third fetch stalls
        id_ready_i = 1'b0;
        fetch(32'h0, 32'hA000_0000);
        fetch(32'h4, 32'hA000_0004);
        pc_i = 32'h8; pc_ce_i = 1'b1;
        #1 chk("full_stall", fetch_stall_o, 1);
        chk("full_req", inst_req_o, 0);
        chk("full_head", id_pc_o, 32'h0);
        tick();
        chk("full_stall2", fetch_stall_o, 1);
        chk("full_req2", inst_req_o, 0);
        tick();
        id_ready_i = 1'b1;
        #1 chk("pop_cyc_stall", fetch_stall_o, 1);
        tick();
        id_ready_i = 1'b0;
        #1 chk("after_pop_stall", fetch_stall_o, 0);
        chk("after_pop_head", id_pc_o, 32'h4);
        tick();
        pc_ce_i = 1'b0; inst_addr_ok_i = 1'b1;
        #1 chk("req8", inst_req_o, 1);
        chk("req8_addr", inst_addr_o, 32'h8);
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hA000_0008;
        tick();
        inst_data_ok_i = 1'b0; id_ready_i = 1'b1;
        #1 chk("drain_pc4", id_pc_o, 32'h4);
        chk("drain_inst4", id_inst_o, 32'hA000_0004);
        tick();
        chk("drain_pc8", id_pc_o, 32'h8);
        chk("drain_inst8", id_inst_o, 32'hA000_0008);
        tick();
        chk("drain_empty", id_valid_o, 0);

        // Flush while waiting for data
        pc_i = 32'h100; pc_ce_i = 1'b1;
        tick();
        pc_ce_i = 1'b0; inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; pc_i = 32'h200; pc_ce_i = 1'b1;
        #1 chk("disc_req", inst_req_o, 0);
        chk("disc_stall", fetch_stall_o, 1);
        chk("disc_valid", id_valid_o, 0);
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
        tick();
        inst_data_ok_i = 1'b0;
        #1 chk("disc_drop", id_valid_o, 0);
        chk("cap200_stall", fetch_stall_o, 0);
        tick();
        pc_ce_i = 1'b0; inst_addr_ok_i = 1'b1;
        #1 chk("req200_addr", inst_addr_o, 32'h200);
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h1111_2222;
        tick();
        inst_data_ok_i = 1'b0;
        #1 chk("f200_valid", id_valid_o, 1);
        chk("f200_pc", id_pc_o, 32'h200);
        chk("f200_inst", id_inst_o, 32'h1111_2222);
        tick();
        chk("f200_alone", id_valid_o, 0);

        // Flush in REQ with addr_ok delayed 3 cycles
        pc_i = 32'h300; pc_ce_i = 1'b1;
        tick();
        pc_ce_i = 1'b0; flush_i = 1'b1;
        #1 chk("rq_fl_req", inst_req_o, 1);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("rq_hold_req", inst_req_o, 1);
            chk("rq_hold_addr", inst_addr_o, 32'h300);
            tick();
        end
        inst_addr_ok_i = 1'b1;
        #1 chk("rq_ok_req", inst_req_o, 1);
        tick();
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hCAFE_0300;
        #1 chk("rq_disc_req", inst_req_o, 0);
        tick();
        inst_data_ok_i = 1'b0;
        #1 chk("rq_nopush", id_valid_o, 0);
        tick();
        chk("rq_nopush2", id_valid_o, 0);

        // Misaligned fetch, then flush empties the buffer
        id_ready_i = 1'b0;
        pc_i = 32'h6; pc_ce_i = 1'b1;
        #1 chk("adel_stall", fetch_stall_o, 0);
        chk("adel_noreq", inst_req_o, 0);
        tick();
        pc_ce_i = 1'b0;
        #1 chk("adel_noreq2", inst_req_o, 0);
        chk("adel_valid", id_valid_o, 1);
        chk("adel_flag", id_adel_o, 1);
        chk("adel_pc", id_pc_o, 32'h6);
        chk("adel_inst", id_inst_o, 32'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1 chk("flush_empty", id_valid_o, 0);
        chk("flush_adel", id_adel_o, 0);

        // Reset during WAIT; late response ignored
        id_ready_i = 1'b1;
        pc_i = 32'h400; pc_ce_i = 1'b1;
        tick();
        pc_ce_i = 1'b0; inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0;
        rst_n_i = 1'b0;
        #1 chk("wrst_req", inst_req_o, 0);
        chk("wrst_addr", inst_addr_o, 0);
        chk("wrst_valid", id_valid_o, 0);
        tick();
        rst_n_i = 1'b1;
        tick();
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h0BAD_0400;
        tick();
        inst_data_ok_i = 1'b0;
        #1 chk("late_valid", id_valid_o, 0);
        chk("late_req", inst_req_o, 0);
        pc_i = 32'h500; pc_ce_i = 1'b1;
        #1 chk("late_idle_cap", fetch_stall_o, 0);
        tick();
        pc_ce_i = 1'b0;
        #1 chk("late_new_req", inst_req_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
